carfield_region_map: RTL and testbench



---
 rtl/carfield_region_map.sv | 194 +++++++++++++++++++
 tb/tb_carfield_region_map.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_region_map.sv
// Runtime-programmable address region map: shadow/active base-size-enable entries behind a
// 32-bit config port, atomic commit, sticky lock, and a 2-stage lookup pipeline.
module carfield_region_map #(
  parameter int unsigned NumRegions = 8,
  parameter int unsigned AddrWidth  = 48,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultBase   = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultSize   = '0,
  parameter logic [NumRegions-1:0]                DefaultEnable = '0,
  localparam int unsigned IdxW = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [10:0]          cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_error_o,
  input  logic                 lk_valid_i,
  output logic                 lk_ready_o,
  input  logic [AddrWidth-1:0] lk_addr_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 res_hit_o,
  output logic [IdxW-1:0]      res_idx_o,
  output logic                 locked_o
);

  localparam int unsigned HiW = AddrWidth - 32;

  logic [NumRegions-1:0][AddrWidth-1:0] sh_base_q, sh_base_d, sh_size_q, sh_size_d;
  logic [NumRegions-1:0][AddrWidth-1:0] act_base_q, act_size_q;
  logic [NumRegions-1:0]                sh_en_q, sh_en_d, act_en_q;
  logic                                 locked_q;

  logic        rvalid_q, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        commit, lock_set, wr_ok, reg_hit, is_ctrl;
  logic [5:0]  reg_idx;
  logic [1:0]  reg_fld;
  logic [7:0]  glb_word;

  logic unused_addr;
  assign unused_addr = ^cfg_addr_i[1:0];

  assign reg_idx  = cfg_addr_i[9:4];
  assign reg_fld  = cfg_addr_i[3:2];
  assign glb_word = cfg_addr_i[9:2];
  assign is_ctrl  = cfg_addr_i[10] && (glb_word == 8'd1);
  assign wr_ok    = cfg_req_i && cfg_we_i && !locked_q;

  always_comb begin
    sh_base_d = sh_base_q;
    sh_size_d = sh_size_q;
    sh_en_d   = sh_en_q;
    commit    = 1'b0;
    lock_set  = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    reg_hit   = 1'b0;
    if (cfg_req_i) begin
      // A CTRL write of 0 stays harmless once locked so software can poll-write safely.
      if (cfg_we_i && locked_q && !(is_ctrl && cfg_wdata_i == '0)) err_d = 1'b1;
      if (!cfg_addr_i[10]) begin
        for (int unsigned i = 0; i < NumRegions; i++) begin
          if (reg_idx == 6'(i)) begin
            reg_hit = 1'b1;
            case (reg_fld)
              2'd0: begin
                rdata_d = sh_base_q[i][31:0];
                if (wr_ok) sh_base_d[i][31:0] = cfg_wdata_i;
              end
              2'd1: begin
                rdata_d = 32'(sh_base_q[i][AddrWidth-1:32]);
                if (wr_ok) sh_base_d[i][AddrWidth-1:32] = cfg_wdata_i[HiW-1:0];
              end
              2'd2: begin
                rdata_d = sh_size_q[i][31:0];
                if (wr_ok) sh_size_d[i][31:0] = cfg_wdata_i;
              end
              default: begin
                rdata_d = 32'(sh_size_q[i][AddrWidth-1:32]);
                if (wr_ok) sh_size_d[i][AddrWidth-1:32] = cfg_wdata_i[HiW-1:0];
              end
            endcase
          end
        end
        if (!reg_hit) err_d = 1'b1;
      end else if (glb_word == 8'd0) begin
        rdata_d = 32'(sh_en_q);
        if (wr_ok) sh_en_d = cfg_wdata_i[NumRegions-1:0];
      end else if (is_ctrl) begin
        rdata_d = {30'b0, locked_q, 1'b0};
        if (wr_ok) begin
          commit   = cfg_wdata_i[0];
          lock_set = cfg_wdata_i[1];
        end
      end else begin
        err_d = 1'b1;
      end
      if (err_d || cfg_we_i) rdata_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_base_q  <= DefaultBase;
      sh_size_q  <= DefaultSize;
      sh_en_q    <= DefaultEnable;
      act_base_q <= DefaultBase;
      act_size_q <= DefaultSize;
      act_en_q   <= DefaultEnable;
      locked_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      sh_base_q <= sh_base_d;
      sh_size_q <= sh_size_d;
      sh_en_q   <= sh_en_d;
      // Commit copies the pre-edge shadow set, so a CTRL write never races a field write.
      if (commit) begin
        act_base_q <= sh_base_q;
        act_size_q <= sh_size_q;
        act_en_q   <= sh_en_q;
      end
      locked_q <= locked_q | lock_set;
      rvalid_q <= cfg_req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign cfg_error_o  = err_q;
  assign locked_o     = locked_q;

  // Lookup pipeline
  logic [NumRegions-1:0] hit_vec, s1_vec_q;
  logic [AddrWidth:0]    diff;
  logic                  s1_valid_q, s2_valid_q, s2_hit_q, s2_ready, enc_hit;
  logic [IdxW-1:0]       s2_idx_q, enc_idx;

  always_comb begin
    hit_vec = '0;
    diff    = '0;
    for (int unsigned i = 0; i < NumRegions; i++) begin
      // One extra bit keeps base+size beyond the address space from wrapping to low addresses.
      diff       = {1'b0, lk_addr_i} - {1'b0, act_base_q[i]};
      hit_vec[i] = act_en_q[i] && (act_size_q[i] != '0) && !diff[AddrWidth] &&
                   (diff[AddrWidth-1:0] < act_size_q[i]);
    end
  end

  always_comb begin
    enc_hit = |s1_vec_q;
    enc_idx = '0;
    for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
      if (s1_vec_q[i]) enc_idx = IdxW'(i);
    end
  end

  assign s2_ready   = !s2_valid_q || res_ready_i;
  assign lk_ready_o = !s1_valid_q || s2_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_idx_q   <= '0;
    end else begin
      if (lk_ready_o) begin
        s1_valid_q <= lk_valid_i;
        if (lk_valid_i) s1_vec_q <= hit_vec;
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_hit_q <= enc_hit;
          s2_idx_q <= enc_idx;
        end
      end
    end
  end

  assign res_valid_o = s2_valid_q;
  assign res_hit_o   = s2_hit_q;
  assign res_idx_o   = s2_idx_q;

endmodule

// File: tb/tb_carfield_region_map.sv
// Directed bench for carfield_region_map: lookup results go through an expectation queue that a
// negedge monitor drains; config responses are checked right after their response edge.
module tb_carfield_region_map;

  localparam logic [7:0][47:0] TbBase = 384'h7800_0000;
  localparam logic [7:0][47:0] TbSize = 384'h2_0000;
  localparam logic [7:0]       TbEn   = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_req = 1'b0, cfg_we = 1'b0;
  logic [10:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_rvalid_o, cfg_error_o, lk_ready_o, res_valid_o, res_hit_o, locked_o;
  logic [31:0] cfg_rdata_o;
  logic        lk_valid = 1'b0, res_ready = 1'b1;
  logic [47:0] lk_addr = '0;
  logic [2:0]  res_idx_o;

  int checks = 0;
  int failures = 0;
  bit rand_mode = 1'b0;
  logic [3:0] exp_q[$];

  carfield_region_map #(
    .NumRegions(8), .AddrWidth(48),
    .DefaultBase(TbBase), .DefaultSize(TbSize), .DefaultEnable(TbEn)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_error_o(cfg_error_o),
    .lk_valid_i(lk_valid), .lk_ready_o(lk_ready_o), .lk_addr_i(lk_addr),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready), .res_hit_o(res_hit_o),
    .res_idx_o(res_idx_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 after checking the response.
  task automatic cfg(input bit we, input logic [10:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input bit exp_err, input string name);
    cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0;
    chk({name, " rvalid"}, 64'(cfg_rvalid_o), 64'(1));
    chk({name, " error"}, 64'(cfg_error_o), 64'(exp_err));
    chk({name, " rdata"}, 64'(cfg_rdata_o), 64'(exp_rd));
  endtask

  task automatic lookup(input logic [47:0] a, input logic [3:0] e);
    int n = 0;
    bit got = 1'b0;
    lk_valid = 1'b1; lk_addr = a;
    while (!got && n < 50) begin
      @(negedge clk);
      if (lk_ready_o) begin
        exp_q.push_back(e);
        got = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    lk_valid = 1'b0;
    chk("lookup accepted", 64'(got), 64'(1));
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 60);
    #1;
    chk("results drained", 64'(exp_q.size()), 64'(0));
  endtask

  // Ready driver: random while streaming, otherwise always ready.
  initial forever begin
    @(posedge clk); #1;
    res_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Result monitor
  initial begin
    logic [3:0] e;
    logic [3:0] prev_res = '0;
    bit prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall valid held", 64'(res_valid_o), 64'(1));
          chk("stall payload held", 64'({res_hit_o, res_idx_o}), 64'(prev_res));
        end
        if (!lk_ready_o) chk("lk_ready low only when full", 64'(res_valid_o && !res_ready),
                             64'(1));
        if (res_valid_o && res_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected result: got %0h expected none", {res_hit_o, res_idx_o});
          end else begin
            e = exp_q.pop_front();
            chk("lookup result", 64'({res_hit_o, res_idx_o}), 64'(e));
          end
        end
        prev_stall = res_valid_o && !res_ready;
        prev_res   = {res_hit_o, res_idx_o};
      end
    end
  end

  logic [47:0] sv_addr[8] = '{48'h7800_0000, 48'h5000_0000, 48'hFFFF_FFFF_F000, 48'h1234,
                              48'h7801_FFFF, 48'h5000_0FFF, 48'h5000_1000, 48'hFFFF_FFFF_FFFF};
  logic [3:0]  sv_exp[8]  = '{4'b1000, 4'b1010, 4'b1011, 4'b0000,
                              4'b1000, 4'b1010, 4'b0000, 4'b1011};

  initial begin
    int i, guard;
    repeat (3) @(posedge clk);
    #1;
    chk("reset locked", 64'(locked_o), 64'(0));
    chk("reset res_valid", 64'(res_valid_o), 64'(0));
    chk("reset rvalid", 64'(cfg_rvalid_o), 64'(0));
    chk("reset rdata", 64'(cfg_rdata_o), 64'(0));
    chk("reset error", 64'(cfg_error_o), 64'(0));
    chk("reset hit/idx", 64'({res_hit_o, res_idx_o}), 64'(0));
    rst = 1'b0;

    // Defaults and latency
    lookup(48'h7801_FFFC, 4'b1000);
    chk("latency cycle 1", 64'(res_valid_o), 64'(0));
    @(posedge clk); #1;
    chk("latency cycle 2", 64'(res_valid_o), 64'(1));
    drain();
    lookup(48'h7802_0000, 4'b0000);
    drain();

    // Shadow writes do not affect lookups until commit
    cfg(1, 11'h010, 32'h5000_0000, 0, 0, "wr r1 base_lo");
    cfg(1, 11'h018, 32'h0080_0000, 0, 0, "wr r1 size_lo");
    cfg(1, 11'h400, 32'h3, 0, 0, "wr enable");
    lookup(48'h5000_0100, 4'b0000);
    drain();
    // Lookup accepted on the commit edge still sees the old map
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 11'h404; cfg_wdata = 32'h1;
    lk_valid = 1'b1; lk_addr = 48'h5000_0100;
    @(negedge clk);
    chk("lk_ready at commit", 64'(lk_ready_o), 64'(1));
    if (lk_ready_o) exp_q.push_back(4'b0000);
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0; lk_valid = 1'b0;
    chk("commit error", 64'(cfg_error_o), 64'(0));
    lookup(48'h5000_0100, 4'b1001);
    drain();
    cfg(0, 11'h010, 0, 32'h5000_0000, 0, "rd r1 base_lo");
    cfg(0, 11'h400, 0, 32'h3, 0, "rd enable");
    cfg(0, 11'h404, 0, 32'h0, 0, "rd ctrl unlocked");

    // Overlap priority
    cfg(1, 11'h020, 32'h5000_0000, 0, 0, "wr r2 base_lo");
    cfg(1, 11'h028, 32'h0000_1000, 0, 0, "wr r2 size_lo");
    cfg(1, 11'h400, 32'h7, 0, 0, "wr enable 7");
    cfg(1, 11'h404, 32'h1, 0, 0, "commit 2");
    lookup(48'h5000_0FFF, 4'b1001);
    drain();
    cfg(1, 11'h400, 32'h5, 0, 0, "wr enable 5");
    cfg(1, 11'h404, 32'h1, 0, 0, "commit 3");
    lookup(48'h5000_0FFF, 4'b1010);
    lookup(48'h5000_1000, 4'b0000);
    drain();

    // Top-of-space region: no wrap to address 0
    cfg(1, 11'h030, 32'hFFFF_F000, 0, 0, "wr r3 base_lo");
    cfg(1, 11'h034, 32'hFFFF_FFFF, 0, 0, "wr r3 base_hi");
    cfg(0, 11'h034, 0, 32'h0000_FFFF, 0, "rd r3 base_hi masked");
    cfg(1, 11'h038, 32'h0000_2000, 0, 0, "wr r3 size_lo");
    cfg(1, 11'h400, 32'hD, 0, 0, "wr enable D");
    cfg(1, 11'h404, 32'h1, 0, 0, "commit 4");
    lookup(48'hFFFF_FFFF_FFFF, 4'b1011);
    lookup(48'h0, 4'b0000);
    drain();

    // Access errors leave state untouched
    cfg(0, 11'h408, 0, 0, 1, "rd unmapped");
    cfg(0, 11'h080, 0, 0, 1, "rd region 8");
    cfg(1, 11'h080, 32'hDEAD_BEEF, 0, 1, "wr region 8");
    cfg(1, 11'h408, 32'h1, 0, 1, "wr unmapped");
    cfg(0, 11'h010, 0, 32'h5000_0000, 0, "rd r1 after errors");
    cfg(0, 11'h400, 0, 32'hD, 0, "rd enable after errors");

    // Back-to-back stream with random backpressure
    rand_mode = 1'b1;
    i = 0; guard = 0;
    lk_valid = 1'b1; lk_addr = sv_addr[0];
    while (i < 8 && guard < 300) begin
      @(negedge clk);
      if (lk_ready_o) begin
        exp_q.push_back(sv_exp[i]);
        i++;
      end
      @(posedge clk); #1;
      if (i < 8) lk_addr = sv_addr[i];
      guard++;
    end
    lk_valid = 1'b0;
    chk("stream all accepted", 64'(i), 64'(8));
    drain();
    rand_mode = 1'b0;
    @(posedge clk); #1;

    // Lock
    cfg(1, 11'h404, 32'h3, 0, 0, "commit+lock");
    chk("locked_o set", 64'(locked_o), 64'(1));
    cfg(0, 11'h404, 0, 32'h2, 0, "rd ctrl locked");
    cfg(1, 11'h010, 32'h1, 0, 1, "wr base while locked");
    cfg(0, 11'h010, 0, 32'h5000_0000, 0, "rd base while locked");
    cfg(1, 11'h404, 32'h0, 0, 0, "wr ctrl 0 locked");
    cfg(1, 11'h404, 32'h1, 0, 1, "commit while locked");
    lookup(48'h5000_0800, 4'b1010);
    drain();

    // Reset with a lookup in flight drops it and restores defaults
    lk_valid = 1'b1; lk_addr = 48'h7800_0000;
    @(posedge clk); #1;
    lk_valid = 1'b0; rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("in-flight dropped", 64'(res_valid_o), 64'(0));
    chk("locked_o cleared", 64'(locked_o), 64'(0));
    rst = 1'b0;
    cfg(0, 11'h010, 0, 32'h0, 0, "rd r1 base default");
    cfg(0, 11'h400, 0, 32'h1, 0, "rd enable default");
    lookup(48'h5000_0100, 4'b0000);
    lookup(48'h7800_0000, 4'b1000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
